// File: rtl/decode_stage_param.sv
`default_nettype none
// ============================================================================
// decode_stage_param : parametrised decode stage with scalar and packed-pixel
//                      vector register files, write-through bypass, ID/EX reg
// Revision: 1.0
// ============================================================================
module decode_stage_param #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4,
    parameter int LANE_W = 8,
    parameter int LANES  = 5,
    parameter int LIDX_W = 3,
    parameter int IMM_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        pc4_in,
    input  logic [ADDR_W-1:0]        rp,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rg_in,
    input  logic [IMM_W-1:0]         imm_in,
    input  logic                     sel_ext,
    input  logic                     sel_imm16,
    input  logic                     sel_a,
    input  logic                     sel_b,
    input  logic                     wb_we_c,
    input  logic [ADDR_W-1:0]        wb_rg,
    input  logic [DATA_W-1:0]        wb_din_c,
    input  logic                     wb_we_v,
    input  logic                     wb_vmode,
    input  logic [LIDX_W-1:0]        wb_lane,
    input  logic [LANE_W-1:0]        wb_din_v,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        pc4_out,
    output logic [ADDR_W-1:0]        rg_out,
    output logic [DATA_W-1:0]        do_a,
    output logic [DATA_W-1:0]        do_b,
    output logic [LANES*LANE_W-1:0]  vec_out,
    output logic [DATA_W-1:0]        imm_out
);

    localparam int VEC_W = LANES * LANE_W;

    logic [NREG-1:0][DATA_W-1:0] sreg_q, sreg_d;
    logic [NREG-1:0][VEC_W-1:0]  vreg_q, vreg_d;

    logic [VEC_W-1:0]  w_vec_old;
    logic [VEC_W-1:0]  w_vec_new;
    logic [15:0]       w_imm_lo;
    logic [DATA_W-1:0] w_imm_ext;

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [ADDR_W-1:0] rg_q,      rg_d;
    logic [DATA_W-1:0] do_a_q,    do_a_d;
    logic [DATA_W-1:0] do_b_q,    do_b_d;
    logic [VEC_W-1:0]  vec_out_q, vec_out_d;
    logic [DATA_W-1:0] imm_q,     imm_d;

    always_comb begin
        sreg_d = sreg_q;
        if (wb_we_c) begin
            sreg_d[wb_rg] = wb_din_c;
        end
    end

    // Shift-in slides every lane up by one; an out-of-range lane index
    // matches no lane and leaves the register unchanged.
    always_comb begin
        w_vec_old = vreg_q[wb_rg];
        w_vec_new = w_vec_old;
        if (wb_vmode) begin
            w_vec_new = (w_vec_old << LANE_W) | VEC_W'(wb_din_v);
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (wb_lane == LIDX_W'(k)) begin
                    w_vec_new[k*LANE_W +: LANE_W] = wb_din_v;
                end
            end
        end
        vreg_d = vreg_q;
        if (wb_we_v) begin
            vreg_d[wb_rg] = w_vec_new;
        end
    end

    always_comb begin
        w_imm_lo = imm_in[15:0];
        if (sel_imm16) begin
            w_imm_ext = sel_ext ? DATA_W'($signed(w_imm_lo)) : DATA_W'(w_imm_lo);
        end else begin
            w_imm_ext = sel_ext ? DATA_W'($signed(imm_in)) : DATA_W'(imm_in);
        end
    end

    // Operands read the post-write file images, which gives write-through.
    always_comb begin
        valid_d   = valid_q;
        pc4_d     = pc4_q;
        rg_d      = rg_q;
        do_a_d    = do_a_q;
        do_b_d    = do_b_q;
        vec_out_d = vec_out_q;
        imm_d     = imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d   = in_valid;
            pc4_d     = pc4_in;
            rg_d      = rg_in;
            do_a_d    = sel_a ? pc4_in : sreg_d[rp];
            do_b_d    = sel_b ? w_imm_ext : sreg_d[rs];
            vec_out_d = vreg_d[rp];
            imm_d     = w_imm_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q    <= '0;
            vreg_q    <= '0;
            valid_q   <= 1'b0;
            pc4_q     <= '0;
            rg_q      <= '0;
            do_a_q    <= '0;
            do_b_q    <= '0;
            vec_out_q <= '0;
            imm_q     <= '0;
        end else begin
            sreg_q    <= sreg_d;
            vreg_q    <= vreg_d;
            valid_q   <= valid_d;
            pc4_q     <= pc4_d;
            rg_q      <= rg_d;
            do_a_q    <= do_a_d;
            do_b_q    <= do_b_d;
            vec_out_q <= vec_out_d;
            imm_q     <= imm_d;
        end
    end

    assign out_valid = valid_q;
    assign pc4_out   = pc4_q;
    assign rg_out    = rg_q;
    assign do_a      = do_a_q;
    assign do_b      = do_b_q;
    assign vec_out   = vec_out_q;
    assign imm_out   = imm_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_param.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_param : bench for decode_stage_param against a lane-level
//                         behavioural model, plus directed literal cases
// Revision: 1.0
// ============================================================================
module tb_decode_stage_param;

    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int ADDR_W = 4;
    localparam int LANE_W = 8;
    localparam int LANES  = 5;
    localparam int LIDX_W = 3;
    localparam int IMM_W  = 24;
    localparam int VEC_W  = LANES * LANE_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid, stall, flush;
    logic [DATA_W-1:0] pc4_in;
    logic [ADDR_W-1:0] rp, rs, rg_in;
    logic [IMM_W-1:0]  imm_in;
    logic              sel_ext, sel_imm16, sel_a, sel_b;
    logic              wb_we_c;
    logic [ADDR_W-1:0] wb_rg;
    logic [DATA_W-1:0] wb_din_c;
    logic              wb_we_v, wb_vmode;
    logic [LIDX_W-1:0] wb_lane;
    logic [LANE_W-1:0] wb_din_v;
    logic              out_valid;
    logic [DATA_W-1:0] pc4_out, do_a, do_b, imm_out;
    logic [ADDR_W-1:0] rg_out;
    logic [VEC_W-1:0]  vec_out;

    decode_stage_param #(
        .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .LANE_W(LANE_W),
        .LANES(LANES), .LIDX_W(LIDX_W), .IMM_W(IMM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .pc4_in(pc4_in), .rp(rp), .rs(rs), .rg_in(rg_in), .imm_in(imm_in),
        .sel_ext(sel_ext), .sel_imm16(sel_imm16), .sel_a(sel_a), .sel_b(sel_b),
        .wb_we_c(wb_we_c), .wb_rg(wb_rg), .wb_din_c(wb_din_c),
        .wb_we_v(wb_we_v), .wb_vmode(wb_vmode), .wb_lane(wb_lane), .wb_din_v(wb_din_v),
        .out_valid(out_valid), .pc4_out(pc4_out), .rg_out(rg_out),
        .do_a(do_a), .do_b(do_b), .vec_out(vec_out), .imm_out(imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: scalar registers and per-lane pixel arrays
    logic [DATA_W-1:0] sm [NREG];
    logic [LANE_W-1:0] vm [NREG][LANES];

    logic              exp_valid;
    logic [DATA_W-1:0] exp_pc4, exp_a, exp_b, exp_imm;
    logic [ADDR_W-1:0] exp_rg;
    logic [VEC_W-1:0]  exp_vec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                  input logic s16, input logic sx);
        longint v;
        if (s16) begin
            v = longint'(imm[15:0]);
            if (sx && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(imm);
            if (sx && v >= (longint'(1) << (IMM_W - 1))) v = v - (longint'(1) << IMM_W);
        end
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [VEC_W-1:0] pack(input int r);
        logic [VEC_W-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) p[k*LANE_W +: LANE_W] = vm[r][k];
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            sm[i] = '0;
            for (int k = 0; k < LANES; k++) vm[i][k] = '0;
        end
        exp_valid = 1'b0; exp_pc4 = '0; exp_rg = '0; exp_a = '0;
        exp_b = '0; exp_vec = '0; exp_imm = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("pc4_out",   64'(pc4_out),   64'(exp_pc4));
            chk("rg_out",    64'(rg_out),    64'(exp_rg));
            chk("do_a",      64'(do_a),      64'(exp_a));
            chk("do_b",      64'(do_b),      64'(exp_b));
            chk("vec_out",   64'(vec_out),   64'(exp_vec));
            chk("imm_out",   64'(imm_out),   64'(exp_imm));
        end
    end

    // One clock: the model applies writes, then reads, then the ID/EX rules.
    task automatic cyc();
        logic [DATA_W-1:0] iv;
        int r;
        @(posedge clk);
        if (rst_n) begin
            r = int'(wb_rg);
            if (wb_we_c) sm[r] = wb_din_c;
            if (wb_we_v) begin
                if (wb_vmode) begin
                    for (int k = LANES - 1; k > 0; k--) vm[r][k] = vm[r][k-1];
                    vm[r][0] = wb_din_v;
                end else if (int'(wb_lane) < LANES) begin
                    vm[r][int'(wb_lane)] = wb_din_v;
                end
            end
            iv = ext_imm(imm_in, sel_imm16, sel_ext);
            if (flush) begin
                exp_valid = 1'b0;
            end else if (!stall) begin
                exp_valid = in_valid;
                exp_pc4   = pc4_in;
                exp_rg    = rg_in;
                exp_a     = sel_a ? pc4_in : sm[int'(rp)];
                exp_b     = sel_b ? iv : sm[int'(rs)];
                exp_vec   = pack(int'(rp));
                exp_imm   = iv;
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic quiet();
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0; pc4_in = '0;
        rp = '0; rs = '0; rg_in = '0; imm_in = '0;
        sel_ext = 1'b0; sel_imm16 = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
        wb_we_c = 1'b0; wb_rg = '0; wb_din_c = '0;
        wb_we_v = 1'b0; wb_vmode = 1'b0; wb_lane = '0; wb_din_v = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'h0);
        chk("rst pc4_out",   64'(pc4_out),   64'h0);
        chk("rst rg_out",    64'(rg_out),    64'h0);
        chk("rst do_a",      64'(do_a),      64'h0);
        chk("rst do_b",      64'(do_b),      64'h0);
        chk("rst vec_out",   64'(vec_out),   64'h0);
        chk("rst imm_out",   64'(imm_out),   64'h0);
        model_clear();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        in_valid  = 1'($urandom);
        stall     = ($urandom_range(0, 4) == 0);
        flush     = ($urandom_range(0, 9) == 0);
        pc4_in    = $urandom;
        rp        = ADDR_W'($urandom_range(0, NREG - 1));
        rs        = ADDR_W'($urandom_range(0, NREG - 1));
        rg_in     = ADDR_W'($urandom);
        imm_in    = IMM_W'($urandom);
        sel_ext   = 1'($urandom);
        sel_imm16 = 1'($urandom);
        sel_a     = ($urandom_range(0, 3) == 0);
        sel_b     = ($urandom_range(0, 3) == 0);
        wb_we_c   = 1'($urandom);
        wb_we_v   = 1'($urandom);
        wb_vmode  = 1'($urandom);
        wb_lane   = LIDX_W'($urandom);
        wb_din_c  = $urandom;
        wb_din_v  = LANE_W'($urandom);
        case ($urandom_range(0, 2))
            0: wb_rg = rp;
            1: wb_rg = rs;
            default: wb_rg = ADDR_W'($urandom);
        endcase
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        in_valid = 1'b0;
        model_clear();
        chk_en = 1'b1;
        @(negedge clk);
        #2;
        do_reset();

        // Fresh registers read as zero
        quiet(); rp = 4'd7; rs = 4'd9;
        cyc();
        chk("post-reset do_a", 64'(do_a), 64'h0);
        chk("post-reset do_b", 64'(do_b), 64'h0);
        chk("post-reset valid", 64'(out_valid), 64'h1);

        // Scalar write-through
        quiet(); wb_we_c = 1'b1; wb_rg = 4'd3; wb_din_c = 32'hDEADBEEF; rp = 4'd3;
        cyc();
        chk("bypass do_a", 64'(do_a), 64'hDEADBEEF);

        // Vector lane writes, shift-in and ignored lane on r5
        quiet(); wb_we_v = 1'b1; wb_rg = 4'd5; wb_lane = 3'd0; wb_din_v = 8'h11; rp = 4'd5;
        cyc();
        wb_lane = 3'd4; wb_din_v = 8'h22;
        cyc();
        chk("lane write", 64'(vec_out), 64'h2200000011);
        wb_vmode = 1'b1; wb_din_v = 8'hAA;
        cyc();
        chk("shift-in", 64'(vec_out), 64'h00000011AA);
        wb_vmode = 1'b0; wb_lane = 3'd7; wb_din_v = 8'h55;
        cyc();
        chk("lane 7 ignored", 64'(vec_out), 64'h00000011AA);

        // Immediate extension and operand mux
        quiet(); sel_b = 1'b1; imm_in = 24'h00F000; sel_imm16 = 1'b1; sel_ext = 1'b1;
        cyc();
        chk("imm16 sext", 64'(imm_out), 64'hFFFFF000);
        chk("do_b = imm", 64'(do_b), 64'hFFFFF000);
        sel_ext = 1'b0;
        cyc();
        chk("imm16 zext", 64'(imm_out), 64'h0000F000);
        imm_in = 24'h800000; sel_imm16 = 1'b0; sel_ext = 1'b1;
        cyc();
        chk("imm24 sext", 64'(imm_out), 64'hFF800000);
        quiet(); sel_a = 1'b1; pc4_in = 32'h104;
        cyc();
        chk("do_a = pc4", 64'(do_a), 64'h104);

        // Stall for three cycles with changing inputs and a write to r2
        quiet(); pc4_in = 32'h200; rg_in = 4'd9; rp = 4'd1;
        cyc();
        stall = 1'b1; pc4_in = 32'h300; rg_in = 4'd4;
        wb_we_c = 1'b1; wb_rg = 4'd2; wb_din_c = 32'hCAFE0002;
        cyc();
        chk("stall pc4 1", 64'(pc4_out), 64'h200);
        wb_we_c = 1'b0; pc4_in = 32'h304; in_valid = 1'b0;
        cyc();
        chk("stall rg 2", 64'(rg_out), 64'h9);
        pc4_in = 32'h308; sel_a = 1'b1;
        cyc();
        chk("stall valid 3", 64'(out_valid), 64'h1);
        quiet(); rp = 4'd2; pc4_in = 32'h204;
        cyc();
        chk("write seen after stall", 64'(do_a), 64'hCAFE0002);
        flush = 1'b1; stall = 1'b1; pc4_in = 32'h208;
        cyc();
        chk("flush valid", 64'(out_valid), 64'h0);
        chk("flush holds pc4", 64'(pc4_out), 64'h204);

        // Randomized run with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            rand_inputs();
            cyc();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
